sio_device_link: RTL and testbench

Device-end peer of the POKEY serial port for the Atari SIO bus. Receives 8N1 bytes that POKEY drives on SOD and frames the 5-byte command frame while the command line is low. It checks the device ID and checksum, returns ACK/NAK on SID, and streams host-supplied response bytes back to POKEY. It is used as an in-fabric disk/peripheral emulator and as the bench partner for the POKEY serial core.

---
 rtl/sio_device_link_pkg.sv | 38 +++
 rtl/sio_device_link_if.sv | 30 +++
 rtl/sio_byte_rx.sv | 99 +++++++++
 rtl/sio_device_link.sv | 226 ++++++++++++++++++++++
 tb/tb_sio_device_link.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sio_device_link_pkg.sv
// Shared types, SIO protocol bytes and checksum helper for the
// SIO device link: frame/receiver state encodings and the SIO constants.
package sio_device_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_RX,
        ST_ACK_WAIT,
        ST_TX_ACK,
        ST_RESP
    } link_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] SIO_ACK      = 8'h41;
    localparam logic [7:0] SIO_NAK      = 8'h4E;
    localparam logic [7:0] SIO_COMPLETE = 8'h43;
    localparam logic [7:0] SIO_ERROR    = 8'h45;

    localparam int FRAME_LEN = 5;

    // One step of the SIO checksum: 8-bit add with end-around carry.
    // The carry can never ripple twice, since the raw sum is <= 9'h1FE.
    function automatic logic [7:0] sio_chk_add(
        input logic [7:0] s,
        input logic [7:0] b
    );
        logic [8:0] t;
        t = {1'b0, s} + {1'b0, b};
        return t[7:0] + {7'd0, t[8]};
    endfunction

endpackage

// File: rtl/sio_device_link_if.sv
// SIO bus plus host-side response port of the device link.
// master: POKEY/host side; slave: the device link itself.
interface sio_device_link_if;

    logic       SOD;
    logic       nCMD;
    logic       SID;
    logic       cmdStrobe;
    logic [7:0] cmdByte;
    logic [7:0] aux1;
    logic [7:0] aux2;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       frameErr;
    logic       chkErr;

    modport master (
        output SOD, nCMD, txData, txValid,
        input  SID, cmdStrobe, cmdByte, aux1, aux2,
        input  txReady, frameErr, chkErr
    );

    modport slave (
        input  SOD, nCMD, txData, txValid,
        output SID, cmdStrobe, cmdByte, aux1, aux2,
        output txReady, frameErr, chkErr
    );

endinterface

// File: rtl/sio_byte_rx.sv
// 8N1 receiver on an already-synchronized line.
// Ports: clk, rst_i (sync), clear_i (drop partial byte), rxd_i,
// byte_o, byteValid_o (1-cycle pulse), stopErr_o (with byteValid_o).
module sio_byte_rx
    import sio_device_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 93
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byteValid_o,
    output logic       stopErr_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          prev_q;
    logic          valid_q;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // prev_q keeps tracking the line through a clear so a
            // line already low is not mistaken for a new start edge.
            prev_q  <= rxd_i;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (clear_i) begin
                state_q <= RX_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    RX_IDLE: begin
                        if (prev_q && !rxd_i) begin
                            state_q <= RX_START;
                            cnt_q   <= '0;
                        end
                    end
                    RX_START: begin
                        if (cnt_q == HALF_LAST) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            // A high mid-start sample is a glitch.
                            state_q <= rxd_i ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q <= '0;
                            sh_q  <= {rxd_i, sh_q[7:1]};
                            if (bit_q == 3'd7) begin
                                state_q <= RX_STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            err_q   <= ~rxd_i;
                            state_q <= RX_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    assign byte_o      = sh_q;
    assign byteValid_o = valid_q;
    assign stopErr_o   = err_q;

endmodule

// File: rtl/sio_device_link.sv
// Device end of the Atari SIO link: frames command bytes, answers
// ACK/NAK and streams host bytes. Ports: clk, Init, bus (slave).
module sio_device_link
    import sio_device_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 93,
    parameter logic [7:0]  DEV_ID       = 8'h31,
    parameter int unsigned ACK_DELAY    = 186
) (
    input logic              clk,
    input logic              Init,
    sio_device_link_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int WW = $clog2(ACK_DELAY + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_DELAY - 1);

    logic sod_s1_q, sod_s2_q;
    logic ncmd_s1_q, ncmd_s2_q, ncmd_q;

    link_state_e   state_q;
    logic [7:0]    frame_q [FRAME_LEN];
    logic [2:0]    idx_q;
    logic          bad_q;
    logic          ack_q;
    logic [WW-1:0] wait_q;

    logic          tx_busy_q;
    logic [8:0]    tx_sh_q;
    logic [3:0]    tx_bits_q;
    logic [CW-1:0] tx_cnt_q;

    logic       sid_q;
    logic       strobe_q;
    logic       ferr_q;
    logic       cerr_q;
    logic [7:0] cmd_q, aux1_q, aux2_q;

    logic       ncmd_fall, ncmd_rise;
    logic       tx_last, tx_ready, tx_fire;
    logic       frame_ok;
    logic [7:0] chk_sum;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    always_ff @(posedge clk) begin
        if (Init) begin
            sod_s1_q  <= 1'b1;
            sod_s2_q  <= 1'b1;
            ncmd_s1_q <= 1'b1;
            ncmd_s2_q <= 1'b1;
            ncmd_q    <= 1'b1;
        end else begin
            sod_s1_q  <= bus.SOD;
            sod_s2_q  <= sod_s1_q;
            ncmd_s1_q <= bus.nCMD;
            ncmd_s2_q <= ncmd_s1_q;
            ncmd_q    <= ncmd_s2_q;
        end
    end

    assign ncmd_fall = ncmd_q & ~ncmd_s2_q;
    assign ncmd_rise = ~ncmd_q & ncmd_s2_q;

    // A byte still in flight when nCMD rises is dropped.
    sio_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_i      (Init),
        .clear_i    (ncmd_rise),
        .rxd_i      (sod_s2_q),
        .byte_o     (rx_byte),
        .byteValid_o(rx_valid),
        .stopErr_o  (rx_err)
    );

    always_comb begin
        chk_sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk_sum = sio_chk_add(chk_sum, frame_q[i]);
        end
    end

    // idx_q saturates at 7, so more than five bytes never looks valid.
    assign frame_ok = (idx_q == 3'd5) & ~bad_q
                    & (frame_q[0] == DEV_ID);

    assign tx_last = tx_busy_q & (tx_bits_q == 4'd0)
                   & (tx_cnt_q == BIT_LAST);

    // Ready during the final stop-bit cycle keeps host bytes gapless;
    // a simultaneous nCMD fall wins over the handshake.
    assign tx_ready = (state_q == ST_RESP)
                    & (~tx_busy_q | tx_last) & ~ncmd_fall;
    assign tx_fire  = bus.txValid & tx_ready;

    always_ff @(posedge clk) begin
        if (Init) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            bad_q     <= 1'b0;
            ack_q     <= 1'b0;
            wait_q    <= '0;
            tx_busy_q <= 1'b0;
            tx_sh_q   <= '1;
            tx_bits_q <= '0;
            tx_cnt_q  <= '0;
            sid_q     <= 1'b1;
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
            cerr_q    <= 1'b0;
            cmd_q     <= '0;
            aux1_q    <= '0;
            aux2_q    <= '0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            cerr_q   <= 1'b0;

            // Shifter: tx_sh_q holds data then stop; tx_bits_q counts
            // bits still to follow the one currently on SID.
            if (tx_busy_q) begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_q <= '0;
                    if (tx_bits_q == 4'd0) begin
                        tx_busy_q <= 1'b0;
                    end else begin
                        sid_q     <= tx_sh_q[0];
                        tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
                        tx_bits_q <= tx_bits_q - 1'b1;
                    end
                end else begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                end
            end

            if (ncmd_fall) begin
                state_q   <= ST_CMD_RX;
                idx_q     <= '0;
                bad_q     <= 1'b0;
                tx_busy_q <= 1'b0;
                sid_q     <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: state_q <= ST_IDLE;
                    ST_CMD_RX: begin
                        if (ncmd_rise) begin
                            if (frame_ok) begin
                                state_q <= ST_ACK_WAIT;
                                wait_q  <= '0;
                                ack_q   <= (chk_sum == frame_q[4]);
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else if (rx_valid) begin
                            if (rx_err) begin
                                bad_q  <= 1'b1;
                                ferr_q <= 1'b1;
                            end
                            for (int i = 0; i < FRAME_LEN; i++) begin
                                if (idx_q == 3'(i)) begin
                                    frame_q[i] <= rx_byte;
                                end
                            end
                            if (idx_q != 3'd7) begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    ST_ACK_WAIT: begin
                        if (wait_q == WAIT_LAST) begin
                            state_q   <= ST_TX_ACK;
                            tx_busy_q <= 1'b1;
                            tx_cnt_q  <= '0;
                            tx_bits_q <= 4'd9;
                            sid_q     <= 1'b0;
                            tx_sh_q   <= {1'b1,
                                          ack_q ? SIO_ACK : SIO_NAK};
                            if (ack_q) begin
                                strobe_q <= 1'b1;
                                cmd_q    <= frame_q[1];
                                aux1_q   <= frame_q[2];
                                aux2_q   <= frame_q[3];
                            end else begin
                                cerr_q <= 1'b1;
                            end
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    ST_TX_ACK: begin
                        if (tx_last) begin
                            state_q <= ack_q ? ST_RESP : ST_IDLE;
                        end
                    end
                    ST_RESP: begin
                        if (tx_fire) begin
                            tx_busy_q <= 1'b1;
                            tx_cnt_q  <= '0;
                            tx_bits_q <= 4'd9;
                            sid_q     <= 1'b0;
                            tx_sh_q   <= {1'b1, bus.txData};
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.SID       = sid_q;
    assign bus.cmdStrobe = strobe_q;
    assign bus.cmdByte   = cmd_q;
    assign bus.aux1      = aux1_q;
    assign bus.aux2      = aux2_q;
    assign bus.txReady   = tx_ready;
    assign bus.frameErr  = ferr_q;
    assign bus.chkErr    = cerr_q;

endmodule

// File: tb/tb_sio_device_link.sv
// Bench for sio_device_link: POKEY-side driver, SID decoder and
// a frame-level reference model of the ACK/NAK/silent decision.
`timescale 1ns/1ps
module tb_sio_device_link;

    localparam int CPB = 8;
    localparam int AD  = 20;
    localparam logic [7:0] ID = 8'h31;

    logic clk  = 1'b0;
    logic Init = 1'b1;
    always #5 clk = ~clk;

    sio_device_link_if bus ();

    sio_device_link #(
        .CLKS_PER_BIT(CPB),
        .DEV_ID      (ID),
        .ACK_DELAY   (AD)
    ) dut (
        .clk (clk),
        .Init(Init),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_strobe = 0, n_cerr = 0, n_ferr = 0;
    int n_ready = 0, n_acc = 0, n_low = 0;

    logic [7:0] fb [6];
    logic [7:0] host_q [$];
    logic [8:0] dq [$];
    int         dt [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.cmdStrobe) n_strobe++;
        if (bus.chkErr)    n_cerr++;
        if (bus.frameErr)  n_ferr++;
        if (bus.txReady)   n_ready++;
        if (bus.txReady && bus.txValid) n_acc++;
        if (bus.SID !== 1'b1) n_low++;
    end

    // UART decoder on SID: queues {stop, data} and start cycle.
    initial begin : sid_dec
        logic [7:0] d;
        logic       s;
        int         t;
        forever begin
            @(negedge clk);
            if (bus.SID === 1'b0) begin
                t = cyc;
                repeat (CPB / 2 - 1) @(negedge clk);
                if (bus.SID === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        d[i] = bus.SID;
                    end
                    repeat (CPB) @(negedge clk);
                    s = bus.SID;
                    dq.push_back({s, d});
                    dt.push_back(t);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_sum();
        int s;
        s = fb[0] + fb[1] + fb[2] + fb[3];
        while (s > 255) s = (s & 255) + (s >> 8);
        return 8'(s);
    endfunction

    // 0 = silent, 1 = ACK, 2 = NAK
    function automatic int model(int n, int ferr);
        if (n != 5) return 0;
        if (ferr >= 0 && ferr < n) return 0;
        if (fb[0] != ID) return 0;
        return (ref_sum() == fb[4]) ? 1 : 2;
    endfunction

    task automatic set_fb(logic [7:0] b0, logic [7:0] b1,
                          logic [7:0] b2, logic [7:0] b3,
                          logic [7:0] b4);
        fb[0] = b0; fb[1] = b1; fb[2] = b2;
        fb[3] = b3; fb[4] = b4; fb[5] = 8'h00;
    endtask

    task automatic send_byte(logic [7:0] b, logic stop);
        bus.SOD = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            bus.SOD = b[i];
            repeat (CPB) tick();
        end
        bus.SOD = stop;
        repeat (CPB) tick();
        bus.SOD = 1'b1;
        if (!stop) repeat (CPB) tick();
    endtask

    task automatic send_frame(int n, int ferr);
        bus.nCMD = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < n; i++) send_byte(fb[i], i != ferr);
        repeat (2 * CPB) tick();
    endtask

    task automatic wait_rx(int k);
        int g = 0;
        while (dq.size() < k && g < 12 * CPB * k + 50) begin
            tick();
            g++;
        end
        check("sid_frames", dq.size() >= k, 1);
    endtask

    task automatic flush();
        repeat (12 * CPB) tick();
        dq.delete();
        dt.delete();
    endtask

    task automatic run_frame(int n, int ferr);
        int exp, s0, c0, f0, r0, a0, lat, g, np;
        exp = model(n, ferr);
        s0 = n_strobe;
        c0 = n_cerr;
        f0 = n_ferr;
        send_frame(n, ferr);
        r0 = n_ready;
        dq.delete();
        dt.delete();
        bus.nCMD = 1'b1;
        lat = 0;
        while (bus.SID === 1'b1 && lat < AD + 12) begin
            tick();
            lat++;
        end
        check("ferr_pulses", n_ferr - f0,
              (ferr >= 0 && ferr < n) ? 1 : 0);
        if (exp == 0) begin
            check("silent_sid", bus.SID, 1);
            check("silent_pulses",
                  (n_strobe - s0) + (n_cerr - c0), 0);
            check("silent_ready", n_ready - r0, 0);
        end else begin
            check("ack_latency", lat, AD + 3);
            wait_rx(1);
            check("ack_byte", (dq.size() > 0) ? dq[0] : 9'h0,
                  {1'b1, (exp == 1) ? 8'h41 : 8'h4E});
            check("strobe_cnt", n_strobe - s0, (exp == 1) ? 1 : 0);
            check("chkerr_cnt", n_cerr - c0, (exp == 2) ? 1 : 0);
            if (exp == 1) begin
                check("cmd_fields",
                      {bus.cmdByte, bus.aux1, bus.aux2},
                      {fb[1], fb[2], fb[3]});
                np = host_q.size();
                if (np > 0) begin
                    a0 = n_acc;
                    bus.txValid = 1'b1;
                    for (int j = 0; j < np; j++) begin
                        bus.txData = host_q[j];
                        g = 0;
                        while (!bus.txReady && g < 40 * CPB) begin
                            tick();
                            g++;
                        end
                        tick();
                    end
                    bus.txValid = 1'b0;
                    wait_rx(1 + np);
                    check("acc_cnt", n_acc - a0, np);
                    for (int j = 0; j < np; j++) begin
                        if (dq.size() > 1 + j) begin
                            check("resp_byte", dq[1 + j],
                                  {1'b1, host_q[j]});
                        end
                        if (j > 0 && dt.size() > 1 + j) begin
                            check("resp_gap", dt[1 + j] - dt[j],
                                  10 * CPB);
                        end
                    end
                end
            end else begin
                repeat (10 * CPB) tick();
                check("nak_ready", n_ready - r0, 0);
            end
        end
    endtask

    initial begin : main
        int a0, l0, g, kind, n, ferr;
        bus.SOD     = 1'b1;
        bus.nCMD    = 1'b1;
        bus.txData  = 8'h00;
        bus.txValid = 1'b0;
        repeat (4) tick();
        check("rst_sid", bus.SID, 1);
        check("rst_ready", bus.txReady, 0);
        check("rst_pulses",
              {bus.cmdStrobe, bus.frameErr, bus.chkErr}, 0);
        check("rst_fields", {bus.cmdByte, bus.aux1, bus.aux2}, 0);
        Init = 1'b0;
        repeat (4) tick();

        set_fb(8'h31, 8'h52, 8'h01, 8'h00, 8'h84);
        host_q = '{8'h43, 8'hAA, 8'h55};
        run_frame(5, -1);
        host_q.delete();

        set_fb(8'h31, 8'h52, 8'h01, 8'h00, 8'h85);
        run_frame(5, -1);

        set_fb(8'h32, 8'h52, 8'h01, 8'h00, 8'h85);
        run_frame(5, -1);

        set_fb(8'h31, 8'h52, 8'h01, 8'h00, 8'h84);
        run_frame(5, 2);
        run_frame(5, -1);

        // Abort a response byte (all zero bits) mid-flight.
        bus.txData  = 8'h00;
        bus.txValid = 1'b1;
        g = 0;
        while (!bus.txReady && g < 40 * CPB) begin
            tick();
            g++;
        end
        tick();
        repeat (3 * CPB) tick();
        check("abort_pre", bus.SID, 0);
        a0 = n_acc;
        bus.nCMD = 1'b0;
        tick();
        tick();
        check("abort_hold", bus.SID, 0);
        tick();
        check("abort_sid", bus.SID, 1);
        l0 = n_low;
        repeat (3 * CPB) tick();
        check("abort_idle", n_low - l0, 0);
        check("abort_noacc", n_acc - a0, 0);
        bus.txValid = 1'b0;
        bus.nCMD = 1'b1;
        repeat (AD + 20) tick();
        check("abort_quiet", n_low - l0, 0);
        flush();

        // Init in the middle of the ACK byte.
        set_fb(8'h31, 8'h52, 8'h01, 8'h00, 8'h84);
        send_frame(5, -1);
        bus.nCMD = 1'b1;
        g = 0;
        while (bus.SID === 1'b1 && g < AD + 12) begin
            tick();
            g++;
        end
        check("init_ack_seen", bus.SID, 0);
        repeat (2 * CPB) tick();
        Init = 1'b1;
        tick();
        check("init_sid", bus.SID, 1);
        check("init_ready", bus.txReady, 0);
        check("init_pulses",
              {bus.cmdStrobe, bus.frameErr, bus.chkErr}, 0);
        check("init_fields", {bus.cmdByte, bus.aux1, bus.aux2}, 0);
        Init = 1'b0;
        l0 = n_low;
        a0 = n_strobe;
        repeat (AD + 40) tick();
        check("init_quiet", n_low - l0, 0);
        check("init_nostrobe", n_strobe - a0, 0);
        flush();

        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 4);
            n    = 5;
            ferr = -1;
            fb[0] = ID;
            for (int i = 1; i < 6; i++) fb[i] = 8'($urandom);
            if (kind == 2) fb[0] = ID ^ 8'($urandom_range(1, 255));
            fb[4] = ref_sum();
            if (kind == 1) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
            if (kind == 3) begin
                n = $urandom_range(1, 5);
                if (n == 5) n = 6;
            end
            if (kind == 4) ferr = $urandom_range(0, 4);
            host_q.delete();
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                host_q.push_back(8'($urandom));
            end
            run_frame(n, ferr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
